decode3_8_player: RTL and testbench

//  Return path of the 8-3 priority-encoder lab. Accepts 3-bit codes over a valid/ready input,

---
 rtl/decode_pkg.sv | 30 +++
 rtl/code_fifo.sv | 64 ++++++
 rtl/decode3_8_player.sv | 128 ++++++++++++
 tb/tb_decode3_8_player.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types and tables for the 3-to-8 code player.
// FSM state enum, seven-segment lookup table and decode helpers.
package decode_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  // Active-low {a,b,c,d,e,f,g,dp}; dp is always off.
  localparam logic [7:0] SEG_LUT [0:7] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D,
    8'h99, 8'h49, 8'h41, 8'h1F
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_of(
    input logic [2:0] code
  );
    return SEG_LUT[code];
  endfunction

  function automatic logic [7:0] onehot_of(
    input logic [2:0] code
  );
    return 8'(1) << code;
  endfunction

endpackage

// File: rtl/code_fifo.sv
// Small circular FIFO holding queued codes for the player.
// Ports: clk, rst_n (async low), i_push/i_data, i_pop, o_head, o_level, o_full.
module code_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [LW-1:0]    r_level;

  logic w_push_ok;
  logic w_pop_ok;

  // Full is judged on the registered level, so a push
  // while full is lost even if a pop frees a slot.
  assign w_push_ok = i_push && (r_level != FULL_LVL);
  assign w_pop_ok  = i_pop && (r_level != '0);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd <= r_rd + AW'(1);
      end
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_level = r_level;
  assign o_full  = (r_level == FULL_LVL);

endmodule

// File: rtl/decode3_8_player.sv
// Buffers 3-bit codes and shows each on one-hot LEDs and a 7-seg digit.
// Ports: clk, rst_n, en, in_valid/in_code/in_ready, out, out_valid, seg, level.
module decode3_8_player
  import decode_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [2:0]             in_code,
  output logic                   in_ready,
  output logic [7:0]             out,
  output logic                   out_valid,
  output logic [7:0]             seg,
  output logic [$clog2(DEPTH):0] level
);

  localparam int TW = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] RELOAD = TW'(HOLD_CYCLES - 1);

  logic [$clog2(DEPTH):0] w_level;
  logic [2:0]             w_head;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_has;

  state_e        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_cur;
  logic          r_valid;
  logic [7:0]    r_out;
  logic [7:0]    r_seg;

  state_e        w_nxt_state;
  logic [TW-1:0] w_nxt_timer;
  logic [2:0]    w_nxt_cur;
  logic          w_nxt_valid;

  assign in_ready = !w_full;
  assign w_push   = in_valid && in_ready;
  assign w_has    = (w_level != '0);

  code_fifo #(
    .WIDTH (3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (in_code),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_level (w_level),
    .o_full  (w_full)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_timer = r_timer;
    w_nxt_cur   = r_cur;
    w_nxt_valid = r_valid;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (en && w_has) begin
          w_pop       = 1'b1;
          w_nxt_cur   = w_head;
          w_nxt_timer = RELOAD;
          w_nxt_valid = 1'b1;
          w_nxt_state = SHOW;
        end
      end
      SHOW: begin
        if (!en) begin
          // Code on display is dropped; queue stays.
          w_nxt_valid = 1'b0;
          w_nxt_timer = '0;
          w_nxt_state = IDLE;
        end else if (r_timer != '0) begin
          w_nxt_timer = r_timer - TW'(1);
        end else if (w_has) begin
          // Back-to-back: next code with no blank cycle.
          w_pop       = 1'b1;
          w_nxt_cur   = w_head;
          w_nxt_timer = RELOAD;
        end else begin
          w_nxt_valid = 1'b0;
          w_nxt_state = IDLE;
        end
      end
      default: begin
        w_nxt_valid = 1'b0;
        w_nxt_timer = '0;
        w_nxt_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_cur   <= '0;
      r_valid <= 1'b0;
      r_out   <= '0;
      r_seg   <= SEG_BLANK;
    end else begin
      r_state <= w_nxt_state;
      r_timer <= w_nxt_timer;
      r_cur   <= w_nxt_cur;
      r_valid <= w_nxt_valid;
      r_out   <= w_nxt_valid ? onehot_of(w_nxt_cur)
                             : 8'h00;
      r_seg   <= w_nxt_valid ? seg_of(w_nxt_cur)
                             : SEG_BLANK;
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;
  assign seg       = r_seg;
  assign level     = w_level;

endmodule

// File: tb/tb_decode3_8_player.sv
// Self-checking bench for decode3_8_player.
// Queue-based playback model plus directed literal checks.
module tb_decode3_8_player;

  localparam int HOLD = 4;
  localparam int DEP  = 4;

  localparam logic [7:0] SEGT [8] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D,
    8'h99, 8'h49, 8'h41, 8'h1F
  };

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       en       = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code  = 3'd0;
  logic       in_ready;
  logic [7:0] out;
  logic       out_valid;
  logic [7:0] seg;
  logic [2:0] level;

  int n_chk = 0;
  int n_err = 0;
  bit run   = 1'b0;

  always #5 clk = ~clk;

  decode3_8_player #(
    .HOLD_CYCLES (HOLD),
    .DEPTH       (DEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .seg       (seg),
    .level     (level)
  );

  // Model: a queue of codes and the code on show
  // with the number of display cycles it has left.
  int q[$];
  bit m_show = 1'b0;
  int m_cur  = 0;
  int m_rem  = 0;
  bit m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_show = 1'b0;
      m_cur  = 0;
      m_rem  = 0;
    end else begin
      m_acc = in_valid && (q.size() != DEP);
      if (!en) begin
        m_show = 1'b0;
      end else if (m_show && m_rem > 1) begin
        m_rem--;
      end else if (q.size() > 0) begin
        m_cur  = q.pop_front();
        m_rem  = HOLD;
        m_show = 1'b1;
      end else begin
        m_show = 1'b0;
      end
      if (m_acc) q.push_back(int'(in_code));
    end
  end

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("m.out", 32'(out),
          m_show ? (32'd1 << m_cur) : 32'd0);
      chk("m.out_valid", 32'(out_valid), 32'(m_show));
      chk("m.seg", 32'(seg),
          m_show ? 32'(SEGT[m_cur]) : 32'hFF);
      chk("m.level", 32'(level), 32'(q.size()));
      chk("m.in_ready", 32'(in_ready),
          32'(q.size() != DEP));
    end
  end

  task automatic drive(
    input logic       v,
    input logic [2:0] c,
    input logic       e
  );
    in_valid = v;
    in_code  = c;
    en       = e;
    @(posedge clk);
    #2;
  endtask

  logic [7:0] t3 [3] = '{8'h80, 8'h01, 8'h04};

  initial begin
    #1 rst_n = 1'b0;
    run = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst.out", 32'(out), 32'h00);
    chk("rst.seg", 32'(seg), 32'hFF);
    chk("rst.level", 32'(level), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);

    // Single code, latency and hold length.
    drive(1'b1, 3'd3, 1'b1);
    chk("t2.lvl", 32'(level), 32'd1);
    chk("t2.pre", 32'(out_valid), 32'd0);
    for (int j = 0; j < HOLD; j++) begin
      drive(1'b0, 3'd0, 1'b1);
      chk("t2.out", 32'(out), 32'h08);
      chk("t2.seg", 32'(seg), 32'h0D);
    end
    drive(1'b0, 3'd0, 1'b1);
    chk("t2.end", 32'(out), 32'h00);
    chk("t2.endseg", 32'(seg), 32'hFF);

    // Back-to-back codes with no gap.
    drive(1'b1, 3'd7, 1'b1);
    chk("t3.pre", 32'(out), 32'h00);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < HOLD; j++) begin
        if (i == 0 && j == 0) drive(1'b1, 3'd0, 1'b1);
        else if (i == 0 && j == 1) drive(1'b1, 3'd2, 1'b1);
        else drive(1'b0, 3'd0, 1'b1);
        chk("t3.out", 32'(out), 32'(t3[i]));
      end
    end
    drive(1'b0, 3'd0, 1'b1);
    chk("t3.end", 32'(out), 32'h00);
    chk("t3.lvl", 32'(level), 32'd0);

    // Fill while disabled; fifth push rejected.
    for (int c = 1; c <= 4; c++) drive(1'b1, 3'(c), 1'b0);
    chk("t4.lvl", 32'(level), 32'd4);
    chk("t4.rdy", 32'(in_ready), 32'd0);
    drive(1'b1, 3'd5, 1'b0);
    chk("t4.lvl5", 32'(level), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      for (int j = 0; j < HOLD; j++) begin
        drive(1'b0, 3'd0, 1'b1);
        chk("t4.out", 32'(out), 32'd1 << i);
      end
    end
    drive(1'b0, 3'd0, 1'b1);
    chk("t4.end", 32'(out), 32'h00);
    chk("t4.lvl0", 32'(level), 32'd0);

    // Push while full on the pop edge is lost.
    for (int c = 4; c <= 7; c++) drive(1'b1, 3'(c), 1'b0);
    drive(1'b1, 3'd0, 1'b1);
    chk("t5.lvl", 32'(level), 32'd3);
    chk("t5.out", 32'(out), 32'h10);
    for (int j = 0; j < 4 * HOLD; j++) drive(1'b0, 3'd0, 1'b1);
    chk("t5.end", 32'(out), 32'h00);
    chk("t5.lvl0", 32'(level), 32'd0);

    // Drop enable mid-show, then resume.
    drive(1'b1, 3'd6, 1'b1);
    drive(1'b1, 3'd1, 1'b1);
    chk("t6.out6", 32'(out), 32'h40);
    drive(1'b1, 3'd4, 1'b1);
    chk("t6.lvl", 32'(level), 32'd2);
    drive(1'b0, 3'd0, 1'b0);
    chk("t6.off", 32'(out), 32'h00);
    chk("t6.offv", 32'(out_valid), 32'd0);
    chk("t6.offlvl", 32'(level), 32'd2);
    drive(1'b0, 3'd0, 1'b0);
    drive(1'b0, 3'd0, 1'b0);
    for (int j = 0; j < HOLD; j++) begin
      drive(1'b0, 3'd0, 1'b1);
      chk("t6.out1", 32'(out), 32'h02);
    end
    for (int j = 0; j < HOLD; j++) begin
      drive(1'b0, 3'd0, 1'b1);
      chk("t6.out4", 32'(out), 32'h10);
    end
    drive(1'b0, 3'd0, 1'b1);
    chk("t6.end", 32'(out), 32'h00);

    // Asynchronous reset while code 5 is on show.
    drive(1'b1, 3'd5, 1'b1);
    drive(1'b1, 3'd6, 1'b1);
    chk("t1.out5", 32'(out), 32'h20);
    chk("t1.seg5", 32'(seg), 32'h49);
    #2 rst_n = 1'b0;
    #1;
    chk("t1.out", 32'(out), 32'h00);
    chk("t1.seg", 32'(seg), 32'hFF);
    chk("t1.lvl", 32'(level), 32'd0);
    chk("t1.rdy", 32'(in_ready), 32'd1);
    chk("t1.v", 32'(out_valid), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1'b0, 3'd0, 1'b1);
    drive(1'b0, 3'd0, 1'b1);
    chk("t1.after", 32'(out), 32'h00);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
